// File: rtl/riscv_data_memory_if.sv
// CPU-side data memory bus: request fields from the master, registered load return from the slave.
interface riscv_data_memory_if;
   logic [31:0] data_memory_address;
   logic [31:0] data_memory_write_data;
   logic        data_memory_mem_write;
   logic        data_memory_mem_read;
   logic [31:0] data_memory_read_data;
   logic        read_valid;

   // No ready: every request is accepted; mem_read=1 on an edge yields read_valid=1 exactly one cycle later.
   modport master (
      output data_memory_address,
      output data_memory_write_data,
      output data_memory_mem_write,
      output data_memory_mem_read,
      input  data_memory_read_data,
      input  read_valid
   );

   modport slave (
      input  data_memory_address,
      input  data_memory_write_data,
      input  data_memory_mem_write,
      input  data_memory_mem_read,
      output data_memory_read_data,
      output read_valid
   );
endinterface

// File: rtl/riscv_data_memory.sv
// Word-addressed data RAM with registered loads and a sticky bus error flag.
// Define RISCV_DMEM_MMIO_EN to map gpio_out at 0x8000_0000 and a cycle counter at 0x8000_0004.
module riscv_data_memory #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                clk,
   input  logic                reset,
   riscv_data_memory_if.slave  bus,
   output logic                bus_error,
   output logic [31:0]         gpio_out
);
   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

   logic [31:0]   mem [DEPTH_WORDS];
   logic [31:0]   read_data_q, read_data_d;
   logic          read_valid_q, read_valid_d;
   logic          bus_error_q, bus_error_d;
   logic [31:0]   addr;
   logic [AW-1:0] word_idx;
   logic          ram_hit, ram_we, mapped;
   logic [31:0]   mmio_rdata;

   assign addr = bus.data_memory_address;

   always_comb begin
      word_idx = addr[AW+1:2];
      ram_hit  = (addr[1:0] == 2'b00) && (addr < RAM_BYTES);
   end

`ifdef RISCV_DMEM_MMIO_EN
   logic [31:0] gpio_q, gpio_d;
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic        gpio_hit, cnt_hit;

   always_comb begin
      gpio_hit    = (addr == 32'h8000_0000);
      cnt_hit     = (addr == 32'h8000_0004);
      gpio_d      = gpio_q;
      if (bus.data_memory_mem_write && gpio_hit) gpio_d = bus.data_memory_write_data;
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      mmio_rdata  = gpio_hit ? gpio_q : (cnt_hit ? cycle_cnt_q : 32'h0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gpio_q      <= '0;
         cycle_cnt_q <= '0;
      end else begin
         gpio_q      <= gpio_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   // Counter writes land here as mapped but have no effect.
   assign mapped   = ram_hit || gpio_hit || cnt_hit;
   assign gpio_out = gpio_q;
`else
   assign mapped     = ram_hit;
   assign mmio_rdata = 32'h0;
   assign gpio_out   = 32'h0;
`endif

   always_comb begin
      ram_we       = bus.data_memory_mem_write && ram_hit;
      read_valid_d = bus.data_memory_mem_read;
      read_data_d  = read_data_q;
      // Unmapped or misaligned reads fall through to mmio_rdata, which is 0 for them.
      if (bus.data_memory_mem_read) read_data_d = ram_hit ? mem[word_idx] : mmio_rdata;
      bus_error_d  = bus_error_q ||
                     ((bus.data_memory_mem_read || bus.data_memory_mem_write) && !mapped);
   end

   // Read data is sampled from the old contents, so a same-edge write is read-before-write.
   always_ff @(posedge clk) begin
      if (!reset && ram_we) mem[word_idx] <= bus.data_memory_write_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         bus_error_q  <= 1'b0;
      end else begin
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         bus_error_q  <= bus_error_d;
      end
   end

   assign bus.data_memory_read_data = read_data_q;
   assign bus.read_valid            = read_valid_q;
   assign bus_error                 = bus_error_q;
endmodule

// File: tb/tb_riscv_data_memory.sv
// Directed bench for riscv_data_memory: RAM, errors, reset behaviour and the optional MMIO region.
module tb_riscv_data_memory;
   logic        clk = 1'b0;
   logic        reset;
   logic        bus_error;
   logic [31:0] gpio_out;

   riscv_data_memory_if bus ();

   riscv_data_memory #(.DEPTH_WORDS(1024)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .bus_error (bus_error),
      .gpio_out  (gpio_out)
   );

   always #5 clk = ~clk;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rd   = '0;
   logic [31:0] cyc_model = '0;
   logic [31:0] obs0, obs1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock edge; verifies read_valid and the registered read_data after it.
   task automatic tick(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rexp);
      logic was_rd;
      logic rst_now;
      bus.data_memory_address    = addr;
      bus.data_memory_write_data = wdata;
      bus.data_memory_mem_read   = rd;
      bus.data_memory_mem_write  = wr;
      rst_now = reset;
      was_rd  = rd && !reset;
      if (was_rd) exp_q.push_back(rexp);
      @(posedge clk);
      cyc_model = rst_now ? 32'h0 : cyc_model + 32'd1;
      #1;
      check($sformatf("read_valid@%08h", addr), 32'(bus.read_valid), 32'(was_rd));
      if (was_rd) last_rd = exp_q.pop_front();
      else if (rst_now) last_rd = '0;
      check($sformatf("read_data@%08h", addr), bus.data_memory_read_data, last_rd);
      bus.data_memory_mem_read  = 1'b0;
      bus.data_memory_mem_write = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      tick(1'b0, 1'b1, addr, data, 32'h0);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
      tick(1'b1, 1'b0, addr, 32'h0, exp);
   endtask

   task automatic idle(input logic [31:0] addr);
      tick(1'b0, 1'b0, addr, 32'h0, 32'h0);
   endtask

   initial begin
      bus.data_memory_address    = '0;
      bus.data_memory_write_data = '0;
      bus.data_memory_mem_read   = 1'b0;
      bus.data_memory_mem_write  = 1'b0;
      reset = 1'b1;
      idle(32'h0);
      idle(32'h0);
      check("reset_bus_error", 32'(bus_error), 32'h0);
      check("reset_gpio", gpio_out, 32'h0);
      reset = 1'b0;

      // basic store then load
      wr(32'h10, 32'hDEAD_BEEF);
      rd(32'h10, 32'hDEAD_BEEF);
      check("basic_bus_error", 32'(bus_error), 32'h0);
      idle(32'h10);

      // read-before-write on the same word
      wr(32'h20, 32'h1111_1111);
      tick(1'b1, 1'b1, 32'h20, 32'h2222_2222, 32'h1111_1111);
      rd(32'h20, 32'h2222_2222);

      // back-to-back reads
      wr(32'h0, 32'h0000_AAAA);
      wr(32'h4, 32'h0000_BBBB);
      wr(32'h8, 32'h0000_CCCC);
      rd(32'h0, 32'h0000_AAAA);
      rd(32'h4, 32'h0000_BBBB);
      rd(32'h8, 32'h0000_CCCC);

      // last RAM word is mapped; idle with odd address raises no error
      wr(32'hFFC, 32'h0BAD_F00D);
      rd(32'hFFC, 32'h0BAD_F00D);
      idle(32'h13);
      idle(32'h8000_1234);
      check("edge_bus_error", 32'(bus_error), 32'h0);

`ifdef RISCV_DMEM_MMIO_EN
      wr(32'h8000_0000, 32'h0000_00A5);
      check("gpio_write", gpio_out, 32'h0000_00A5);
      rd(32'h8000_0000, 32'h0000_00A5);
      wr(32'h8000_0004, 32'h1234_5678);
      check("mmio_bus_error", 32'(bus_error), 32'h0);
      rd(32'h8000_0004, cyc_model);
      obs0 = bus.data_memory_read_data;
      for (int i = 0; i < 4; i++) idle(32'h0);
      rd(32'h8000_0004, cyc_model);
      obs1 = bus.data_memory_read_data;
      check("cnt_delta", obs1 - obs0, 32'd5);
`else
      wr(32'h8000_0000, 32'h0000_00A5);
      check("nommio_bus_error", 32'(bus_error), 32'h1);
      check("nommio_gpio", gpio_out, 32'h0);
      rd(32'h8000_0000, 32'h0);
`endif

      reset = 1'b1;
      idle(32'h0);
      reset = 1'b0;
      check("rst2_bus_error", 32'(bus_error), 32'h0);
      check("rst2_gpio", gpio_out, 32'h0);

      // misaligned and unmapped accesses
      wr(32'h13, 32'h0000_0BAD);
      check("misalign_wr_err", 32'(bus_error), 32'h1);
      rd(32'h10, 32'hDEAD_BEEF);
      rd(32'h1000, 32'h0);
      rd(32'h2, 32'h0);
      idle(32'h0);
      idle(32'h0);
      check("sticky_bus_error", 32'(bus_error), 32'h1);

      // reset mid-operation: read and write on reset edges are dropped
      reset = 1'b1;
      rd(32'h10, 32'hFFFF_FFFF);
      wr(32'h10, 32'h5555_5555);
      check("rst3_bus_error", 32'(bus_error), 32'h0);
      reset = 1'b0;
      rd(32'h10, 32'hDEAD_BEEF);
      check("final_bus_error", 32'(bus_error), 32'h0);
      check("exp_q_drained", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/riscv_data_memory.md
RISCV_DATA_MEMORY -- requirements
Module: riscv_data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the RAM size in 32-bit words (power of two, at least 4).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port data_memory_address, input, 32 bits: byte address from the CPU.
REQ-005 SHALL have port data_memory_write_data, input, 32 bits: store data.
REQ-006 SHALL have port data_memory_mem_write, input, 1 bit: store request.
REQ-007 SHALL have port data_memory_mem_read, input, 1 bit: load request.
REQ-008 SHALL have port data_memory_read_data, output, 32 bits: registered load data.
REQ-009 SHALL have port read_valid, output, 1 bit: one-cycle pulse marking new read_data.
REQ-010 SHALL have port bus_error, output, 1 bit: sticky flag for a misaligned or unmapped access.
REQ-011 SHALL have port gpio_out, output, 32 bits: MMIO output register (see Configuration).

Function
REQ-012 SHALL treat an access as aligned when address[1:0]==0, and as RAM when address < DEPTH_WORDS*4; the word index is address[log2(DEPTH_WORDS)+1:2].
REQ-013 SHALL write write_data to the indexed word on the edge where mem_write=1 for an aligned RAM access.
REQ-014 SHALL, on the edge where mem_read=1 for an aligned RAM access, load the word into read_data and assert read_valid for exactly the following cycle (1-cycle latency).
REQ-015 SHALL accept a new read every cycle; N consecutive read cycles yield N consecutive read_valid cycles.
REQ-016 SHALL, when mem_read and mem_write are both 1 for the same word, return the old contents (read-before-write) and commit the write.
REQ-017 SHALL hold read_data unchanged in cycles without a valid read.
REQ-018 SHALL, for a misaligned or unmapped access (read or write): suppress the write; for a read, load 0 into read_data and still pulse read_valid; set bus_error.
REQ-019 SHALL keep bus_error set once set, until reset.
REQ-020 SHALL perform no action and no error when both mem_read and mem_write are 0, whatever the address.

Reset
REQ-021 SHALL, on any edge with reset=1: set read_data=0, read_valid=0, bus_error=0, gpio_out=0, cycle counter=0.
REQ-022 SHALL ignore reads and writes on reset edges: no RAM write and no read_valid in the following cycle.
REQ-023 SHALL NOT clear RAM contents on reset; the contents are undefined until written.
REQ-024 SHALL resume normal operation on the first edge with reset=0.

Configuration
REQ-025 SHALL use macro RISCV_DMEM_MMIO_EN to compile the MMIO region in or out.
REQ-026 With the macro defined: a write to 0x8000_0000 SHALL load gpio_out; a read of 0x8000_0000 SHALL return gpio_out; a read of 0x8000_0004 SHALL return a free-running 32-bit cycle counter; writes to 0x8000_0004 SHALL be ignored without error.
REQ-027 With the macro defined, the counter SHALL increment by 1 every non-reset cycle and wrap from 0xFFFF_FFFF to 0.
REQ-028 Without the macro: gpio_out SHALL be tied to 0, no counter SHALL exist, and the MMIO addresses SHALL be unmapped as in REQ-018.

Verification
REQ-029 Basic access: write 0xDEADBEEF to 0x10, then read 0x10 -> next cycle read_data=0xDEADBEEF, read_valid=1 for one cycle, bus_error=0.
REQ-030 Simultaneous read and write: 0x20 holds 0x1111_1111; read and write 0x2222_2222 to 0x20 on the same edge -> read_data=0x1111_1111; a later read of 0x20 -> 0x2222_2222.
REQ-031 Errors: write to 0x13 -> RAM word 0x10 unchanged, bus_error=1; read of 0x0000_1000 (DEPTH_WORDS=1024) -> read_data=0, read_valid pulses, bus_error stays 1 until reset.
REQ-032 Back-to-back reads: reads of 0x0, 0x4, 0x8 on three consecutive edges -> three consecutive read_valid cycles with matching data.
REQ-033 Reset mid-operation: reset=1 on the same edge as a read of 0x10 -> no read_valid, read_data=0, bus_error=0; RAM word 0x10 retained.
REQ-034 With RISCV_DMEM_MMIO_EN: write 0xA5 to 0x8000_0000 -> gpio_out=0xA5; two reads of 0x8000_0004 issued 5 cycles apart differ by 5. Without the macro: the same write sets bus_error and gpio_out stays 0.
